// File: rtl/c1_bus_pkg.sv
// C1 bus command codes, master FSM state encoding and op classification helpers.
package c1_bus_pkg;

    typedef enum logic [2:0] {
        C1_NOP          = 3'd0,
        C1_READ8        = 3'd1,
        C1_READ16       = 3'd2,
        C1_READ32       = 3'd3,
        C1_INV_LINE     = 3'd4,
        C1_WRITE8       = 3'd5,
        C1_WRITE16      = 3'd6,
        C1_WRITE32_RESP = 3'd7
    } c1_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR2,
        ST_TURN,
        ST_WAIT,
        ST_BEAT2,
        ST_RESP
    } c1_state_t;

    // NOP and the response code are never issued by the master.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != C1_NOP) && (op != C1_WRITE32_RESP);
    endfunction

    function automatic logic is_write_op(input logic [2:0] op);
        return (op == C1_WRITE8) || (op == C1_WRITE16);
    endfunction

endpackage

// File: rtl/c1_wait_timer.sv
// Response-wait watchdog: counts WAIT cycles and flags the last one allowed.
module c1_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // High during the LIMIT-th WAIT cycle, so WAIT lasts exactly LIMIT cycles.
    assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/c1_master.sv
// C1 bus master: one request at a time, CMD/ADDR2/TURN/WAIT bus sequence.
// Optional response timeout enabled by defining C1_MASTER_TIMEOUT_EN.
module c1_master
    import c1_bus_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [2:0]                                req_op,
    input  logic [MEM_ADDR_SIZE-1:0]                  req_addr,
    input  logic [2*BUS_SIZE-1:0]                     req_wdata,
    output logic                                      rsp_valid,
    output logic [2*BUS_SIZE-1:0]                     rsp_rdata,
    output logic                                      rsp_err,
    output logic                                      busy,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                       data,
    inout  wire  [2:0]                                command
);

    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int XW = 2 * BUS_SIZE;
    localparam logic [BUS_SIZE-1:0] BYTE_MASK = BUS_SIZE'(8'hFF);

    c1_state_t                    state;
    c1_cmd_t                      op_q;
    logic [CACHE_OFFSET_SIZE-1:0] off_q;
    logic [BUS_SIZE-1:0]          wdata_hi;
    logic [BUS_SIZE-1:0]          beat_lo;
    logic [BUS_SIZE-1:0]          data_q;
    logic                         data_oe;
    logic [2:0]                   cmd_q;
    logic                         cmd_oe;

    function automatic logic [XW-1:0] read_word(input c1_cmd_t op, input logic [BUS_SIZE-1:0] bus);
        case (op)
            C1_READ8:  return XW'(bus[7:0]);
            C1_READ16: return XW'(bus);
            default:   return '0;
        endcase
    endfunction

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign command   = cmd_oe  ? cmd_q  : 3'bz;
    assign data      = data_oe ? data_q : {BUS_SIZE{1'bz}};

`ifdef C1_MASTER_TIMEOUT_EN
    logic timed_out;

    c1_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_TURN),
        .run     (state == ST_WAIT),
        .expired (timed_out)
    );
`endif

    // Request fields and bus drive values; only read in states that follow their load.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            op_q     <= c1_cmd_t'(req_op);
            off_q    <= req_addr[CACHE_OFFSET_SIZE-1:0];
            wdata_hi <= req_wdata[XW-1:BUS_SIZE];
            data_q   <= (req_op == C1_WRITE8) ? (req_wdata[BUS_SIZE-1:0] & BYTE_MASK)
                                              : req_wdata[BUS_SIZE-1:0];
        end
        if (state == ST_CMD) begin
            data_q <= wdata_hi;
        end
        if (state == ST_WAIT) begin
            beat_lo <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            address   <= '0;
            cmd_q     <= '0;
            cmd_oe    <= 1'b0;
            data_oe   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_legal_op(req_op)) begin
                            state   <= ST_CMD;
                            cmd_q   <= req_op;
                            cmd_oe  <= 1'b1;
                            address <= req_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                            data_oe <= is_write_op(req_op);
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_CMD: begin
                    state   <= ST_ADDR2;
                    address <= AW'(off_q);
                    // Upper write half needs its own beat only when it cannot ride the CMD beat.
                    data_oe <= (op_q == C1_WRITE16) && (BUS_SIZE < 16);
                end
                ST_ADDR2: begin
                    state   <= ST_TURN;
                    cmd_oe  <= 1'b0;
                    data_oe <= 1'b0;
                    address <= '0;
                end
                ST_TURN: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (command == C1_WRITE32_RESP) begin
                        if (op_q == C1_READ32) begin
                            state <= ST_BEAT2;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= read_word(op_q, data);
                        end
                    end
`ifdef C1_MASTER_TIMEOUT_EN
                    else if (timed_out) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
`endif
                end
                ST_BEAT2: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= {data, beat_lo};
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/c1_master.md
C1_MASTER -- requirements
Module: c1_master

Interface
REQ-001 Parameter MEM_ADDR_SIZE, default 19, SHALL set the full byte-address width.
REQ-002 Parameter BUS_SIZE, default 16, SHALL set the data bus width; the 32-bit transfer width is 2*BUS_SIZE.
REQ-003 Parameter CACHE_OFFSET_SIZE, default 4, SHALL set the offset width; tag+set width is MEM_ADDR_SIZE-CACHE_OFFSET_SIZE.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the response-wait limit and is used only under C1_MASTER_TIMEOUT_EN.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 req_valid / req_ready  in / out  1 / 1  request handshake; transfer on an edge with both high.
REQ-009 req_op  in  3  C1 command code.
REQ-010 req_addr  in  MEM_ADDR_SIZE  byte address.
REQ-011 req_wdata  in  2*BUS_SIZE  write data, low bits used for narrow writes.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  2*BUS_SIZE  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 address  out  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address lines.
REQ-017 data  inout  BUS_SIZE  C1 data lines, 'z when not driven.
REQ-018 command  inout  3  C1 command lines, 'z when not driven.

Function
REQ-019 Codes: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7.
REQ-020 States SHALL be IDLE, CMD, ADDR2, TURN, WAIT, BEAT2, RESP.
REQ-021 req_ready SHALL equal (state==IDLE); requests while busy are not accepted and not lost by the master (requester holds them).
REQ-022 Accepting a legal op (1-6) SHALL latch op/addr/wdata and enter CMD.
REQ-023 Accepting op 0 or 7 SHALL enter RESP directly with rsp_err=1 and rsp_rdata=0; no bus activity.
REQ-024 CMD (1 cycle): command=op, address=req_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE], data=wdata low BUS_SIZE bits for writes (WRITE8: upper bus bits 0), else 'z.
REQ-025 ADDR2 (1 cycle): command=op, address=offset zero-extended, data=wdata upper BUS_SIZE bits only when op is WRITE16 with BUS_SIZE<16 or a 32-bit write path, else 'z.
REQ-026 TURN (1 cycle): command and data 'z; command not sampled.
REQ-027 WAIT: command and data 'z; each rising edge samples command; ==7 ends the wait.
REQ-028 On response for READ8: capture data[7:0], zero-extend; READ16: capture data; READ32: capture data into low half, enter BEAT2.
REQ-029 BEAT2 (1 cycle): capture data into upper half of rsp_rdata unconditionally.
REQ-030 Writes and INV_LINE: response carries no data; rsp_rdata=0.
REQ-031 RESP (1 cycle): rsp_valid=1 with registered rsp_rdata/rsp_err, then IDLE; earliest next accept is the following edge.
REQ-032 Minimum latency accept->rsp_valid: 5 cycles (READ32: 6).
REQ-033 rsp_rdata and rsp_err SHALL hold their last values outside rsp_valid.

Reset
REQ-034 Reset SHALL force IDLE; req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, address=0, data='z, command='z.
REQ-035 Reset mid-transaction SHALL abort without rsp_valid and release the bus from the next cycle.

Configuration
REQ-036 Macro C1_MASTER_TIMEOUT_EN defined: a counter clears on entering WAIT and increments each WAIT cycle; reaching TIMEOUT_CYCLES without response enters RESP with rsp_err=1, rsp_rdata=0.
REQ-037 Macro undefined: WAIT is unbounded; rsp_err is set only by illegal ops; no counter logic present.

Structure
REQ-038 Package c1_bus_pkg SHALL hold the C1 command codes as enum c1_cmd_t and the state typedef.
REQ-039 Sub-module c1_wait_timer (counter + limit compare) SHALL be instantiated only under C1_MASTER_TIMEOUT_EN.

Verification
REQ-040 READ8 addr 0x00002, slave responds 7 with data 0x5555 on first WAIT cycle -> address 0x0000 then 0x2, rsp_valid 5 cycles after accept, rsp_rdata=0x00000055.
REQ-041 WRITE16 addr 0x00022, wdata 0x0000ABCD -> CMD data=0xABCD, command=6 two cycles, then 'z; rsp_valid, rsp_err=0.
REQ-042 READ32, beats 0x1234 then 0x5678 -> rsp_rdata=0x56781234, latency 6.
REQ-043 req_op=0 -> rsp_valid next cycle with rsp_err=1, command stays 'z throughout.
REQ-044 With macro, TIMEOUT_CYCLES=8, slave silent -> rsp_err=1 after 8 WAIT cycles; without macro -> busy stays 1.
REQ-045 Reset asserted in WAIT -> no rsp_valid, req_ready=1 next cycle, bus 'z.
